// File: rtl/c64_amiga_keymap_pkg.sv
// C64 matrix (row*8+col) to Amiga raw keycode ROM and shared constants.
package c64_amiga_keymap_pkg;

  localparam logic [7:0] KEY_UNMAPPED = 8'hFF;
  localparam int         RELEASE_BIT  = 7;

  // Entry 63 (RUN/STOP) stays unmapped: it is claimed by the menu logic.
  localparam logic [7:0] KEYMAP [64] = '{
    8'h41, 8'h44, 8'h4E, 8'h56, 8'h50, 8'h52, 8'h54, 8'h4D,  // DEL RET CRSR-RT F7 F1 F3 F5 CRSR-DN
    8'h03, 8'h11, 8'h20, 8'h04, 8'h31, 8'h21, 8'h12, 8'h60,  // 3 W A 4 Z S E LSHIFT
    8'h05, 8'h13, 8'h22, 8'h06, 8'h33, 8'h23, 8'h14, 8'h32,  // 5 R D 6 C F T X
    8'h07, 8'h15, 8'h24, 8'h08, 8'h35, 8'h25, 8'h16, 8'h34,  // 7 Y G 8 B H U V
    8'h09, 8'h17, 8'h26, 8'h0A, 8'h37, 8'h27, 8'h18, 8'h36,  // 9 I J 0 M K O N
    8'h5E, 8'h19, 8'h28, 8'h0B, 8'h39, 8'h29, 8'h1A, 8'h38,  // + P L - . : @ ,
    8'h0D, 8'h1B, 8'h2A, 8'h46, 8'h61, 8'h0C, 8'h4C, 8'h3A,  // GBP * ; HOME RSHIFT = UP /
    8'h01, 8'h00, 8'h63, 8'h02, 8'h40, 8'h66, 8'h10, 8'hFF   // 1 <- CTRL 2 SPACE C= Q RUN/STOP
  };

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head outputs.
module key_event_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int LEVEL_W = 4
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               push,
  input  logic [DATA_W-1:0]  din,
  output logic               full,
  input  logic               pop,
  output logic               valid,
  output logic [DATA_W-1:0]  dout,
  output logic [LEVEL_W-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [AW-1:0]      rd, wr, rd_n;
  logic [LEVEL_W-1:0] cnt, remain, cnt_n;
  logic               do_push, do_pop;

  // Full comes from the registered count, so a same-cycle pop never frees space.
  always_comb begin
    full    = (cnt == LEVEL_W'(DEPTH));
    do_push = push & ~full;
    do_pop  = pop & valid;
    rd_n    = rd + AW'(do_pop);
    remain  = cnt - LEVEL_W'(do_pop);
    cnt_n   = remain + LEVEL_W'(do_push);
  end

  always_ff @(posedge sysclk)
    if (do_push) mem[wr] <= din;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      rd    <= '0;
      wr    <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      rd    <= rd_n;
      cnt   <= cnt_n;
      valid <= (cnt_n != '0);
      // Head is either an older entry or the word being pushed into an empty queue.
      if (remain != '0)  dout <= mem[rd_n];
      else if (do_push)  dout <= din;
    end
  end

  assign level = cnt;

endmodule

// File: rtl/c64_keymatrix_to_amiga.sv
// Scans the C64 key matrix, debounces over two visits, queues Amiga raw key events.
module c64_keymatrix_to_amiga
  import c64_amiga_keymap_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEVEL_W    = 4
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               ena_1mhz,
  input  logic [63:0]        keys,
  output logic [7:0]         code,
  output logic               code_valid,
  input  logic               code_ready,
  output logic [LEVEL_W-1:0] fifo_level
);

  logic [5:0]  idx;
  logic [63:0] stable, sample;
  logic [7:0]  map_e, ev;
  logic        k, change, mapped, full, push, blocked;

  always_comb begin
    k       = keys[idx];
    map_e   = KEYMAP[idx];
    mapped  = (map_e != KEY_UNMAPPED);
    change  = ena_1mhz & (k == sample[idx]) & (k != stable[idx]);
    blocked = change & mapped & full;
    push    = change & mapped & ~full;
    ev      = {1'b0, map_e[6:0]};
    ev[RELEASE_BIT] = k;
  end

  // A blocked commit leaves both copies alone so the next visit retries it.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      idx    <= '0;
      stable <= '1;
      sample <= '1;
    end else if (ena_1mhz) begin
      idx <= idx + 6'd1;
      if (!blocked)          sample[idx] <= k;
      if (change && !blocked) stable[idx] <= k;
    end
  end

  key_event_fifo #(
    .DATA_W  (8),
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .sysclk (sysclk),
    .reset  (reset),
    .push   (push),
    .din    (ev),
    .full   (full),
    .pop    (code_ready),
    .valid  (code_valid),
    .dout   (code),
    .level  (fifo_level)
  );

endmodule

// File: tb/tb_c64_keymatrix_to_amiga.sv
// Directed bench for the C64 matrix to Amiga key event converter.
module tb_c64_keymatrix_to_amiga;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        ena_1mhz = 1'b0;
  logic        code_ready = 1'b0;
  logic [63:0] keys = '1;
  logic [7:0]  code;
  logic        code_valid;
  logic [3:0]  fifo_level;

  int checks = 0;
  int failures = 0;
  logic [5:0] m;
  logic [7:0] got [$];
  logic [7:0] exp_make [9] = '{8'h41, 8'h44, 8'h4E, 8'h56, 8'h50, 8'h52, 8'h54, 8'h4D, 8'h03};

  c64_keymatrix_to_amiga #(.FIFO_DEPTH(8), .LEVEL_W(4)) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .ena_1mhz   (ena_1mhz),
    .keys       (keys),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .fifo_level (fifo_level)
  );

  always #5 sysclk = ~sysclk;

  // Independent scan position: strobes counted since reset.
  always @(posedge sysclk)
    if (reset) m <= '0;
    else if (ena_1mhz) m <= m + 6'd1;

  // Every accepted event, captured mid-cycle before the popping edge.
  always @(negedge sysclk)
    if (!reset && code_valid && code_ready) got.push_back(code);

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic test_reset;
    bit seen;
    reset = 1'b1; ena_1mhz = 1'b0; keys = '1; code_ready = 1'b0;
    tick(3);
    checks++; if (code_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", code_valid); end
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (code !== 8'h00) begin failures++; $display("FAIL reset_code got=%h exp=00", code); end
    reset = 1'b0; ena_1mhz = 1'b1; code_ready = 1'b1;
    seen = 1'b0;
    repeat (300) begin
      tick();
      if (code_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", seen); end
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL idle_level got=%0d exp=0", fifo_level); end
    checks++; if (code !== 8'h00) begin failures++; $display("FAIL idle_code got=%h exp=00", code); end
  endtask

  task automatic test_press_release;
    int  n;
    bit  found;
    logic [7:0] first;
    got.delete();
    for (int p = 0; p < 2; p++) begin
      keys[1] = (p == 1);
      n = 0; found = 1'b0; first = 8'h00;
      while (!found && n < 140) begin
        tick(); n++;
        if (code_valid) begin found = 1'b1; first = code; end
      end
      checks++;
      if (!found || first !== (p == 0 ? 8'h44 : 8'hC4)) begin
        failures++; $display("FAIL event_code%0d found=%b got=%h exp=%h", p, found, first, (p == 0 ? 8'h44 : 8'hC4));
      end
      // Two visits are required: commit lands 65..128 strobes after the edge.
      checks++;
      if (n < 66 || n > 129) begin failures++; $display("FAIL event_latency%0d got=%0d exp=66..129", p, n); end
    end
    tick(150);
    checks++;
    if (got.size() != 2 || got[0] !== 8'h44 || got[1] !== 8'hC4) begin
      failures++; $display("FAIL press_release_count got=%0d exp=2", got.size());
    end
  endtask

  task automatic test_glitch;
    got.delete();
    keys[0] = 1'b0;
    tick(40);
    keys[0] = 1'b1;
    tick(200);
    checks++; if (got.size() != 0) begin failures++; $display("FAIL glitch_events got=%0d exp=0", got.size()); end
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL glitch_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_unmapped;
    got.delete();
    keys[63] = 1'b0;
    tick(192);
    checks++;
    if (got.size() != 0 || code_valid !== 1'b0) begin
      failures++; $display("FAIL unmapped_press got=%0d valid=%b exp=0", got.size(), code_valid);
    end
    keys[63] = 1'b1;
    tick(140);
    checks++; if (got.size() != 0) begin failures++; $display("FAIL unmapped_release got=%0d exp=0", got.size()); end
  endtask

  task automatic test_fifo_full;
    int n;
    got.delete();
    code_ready = 1'b0;
    n = 0;
    while (m != 6'd9 && n < 70) begin tick(); n++; end
    checks++; if (m !== 6'd9) begin failures++; $display("FAIL align_scan got=%0d exp=9", m); end
    keys[8:0] = '0;
    tick(200);
    checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL full_level got=%0d exp=8", fifo_level); end
    checks++; if (code_valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%b exp=1", code_valid); end
    checks++; if (code !== 8'h41) begin failures++; $display("FAIL full_head got=%h exp=41", code); end
    code_ready = 1'b1;
    tick(150);
    keys[8:0] = '1;
    tick(200);
    checks++; if (got.size() != 18) begin failures++; $display("FAIL drain_count got=%0d exp=18", got.size()); end
    for (int i = 0; i < 18; i++) begin
      logic [7:0] e;
      e = (i < 9) ? exp_make[i] : (exp_make[i-9] | 8'h80);
      checks++;
      if (i >= got.size() || got[i] !== e) begin
        failures++; $display("FAIL drain_order%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hXX, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    got.delete();
    code_ready = 1'b0;
    keys[0] = 1'b0; keys[1] = 1'b0; keys[60] = 1'b0;
    tick(200);
    checks++; if (fifo_level !== 4'd3) begin failures++; $display("FAIL mid_level got=%0d exp=3", fifo_level); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (code_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%b exp=0", code_valid); end
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL mid_reset_level got=%0d exp=0", fifo_level); end
    checks++; if (code !== 8'h00) begin failures++; $display("FAIL mid_reset_code got=%h exp=00", code); end
    keys[0] = 1'b1; keys[1] = 1'b1;
    code_ready = 1'b1;
    tick(200);
    checks++;
    if (got.size() != 1 || got[0] !== 8'h40) begin
      failures++; $display("FAIL rereport got_n=%0d first=%h exp=40", got.size(), (got.size() > 0) ? got[0] : 8'hXX);
    end
    keys[60] = 1'b1;
    tick(150);
    checks++;
    if (got.size() != 2 || got[1] !== 8'hC0) begin
      failures++; $display("FAIL rereport_release got_n=%0d exp=2 with C0", got.size());
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_unmapped();
    test_fifo_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c64_keymatrix_to_amiga.md
Name: c64_keymatrix_to_amiga

Overview:
- Converts the 64-bit C64 keyboard matrix state from the Chameleon I/O block into Amiga raw key events: 7-bit keycode plus bit 7 set for release.
- Sits between the chameleon_io keys output and the keyboard event consumer, i.e. the host keyboard path into the Minimig keyboard logic.
- Scans the matrix sequentially, debounces over two scans and queues events in a small FIFO.
- Presents events on a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..16.
- LEVEL_W, 4, width of fifo_level; must hold FIFO_DEPTH.

Ports:
- sysclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ena_1mhz  in  1  one-sysclk scan strobe at 1 MHz.
- keys  in  64  C64 matrix state, active-low (0 = pressed); index = row*8+col.
- code  out  8  head event: {release, amiga_code[6:0]}.
- code_valid  out  1  FIFO not empty.
- code_ready  in  1  consumer accepts head event.
- fifo_level  out  LEVEL_W  entries queued.

Behaviour:
- Reset (sync, active-high) values:
  - scan index = 0.
  - stable[63:0] = all ones; sample[63:0] = all ones.
  - FIFO emptied; code_valid = 0; code = 8'h00; fifo_level = 0.
- Scanner:
  - 6-bit index advances by 1 on each cycle with ena_1mhz = 1.
  - Wraps 63 -> 0, so a full scan takes 64 strobes.
- Debounce, on an ena_1mhz cycle for index i:
  - Let k = keys[i], captured that cycle.
  - If k == sample[i] and k != stable[i], a change is committed.
  - sample[i] <= k on every visit.
  - A change therefore needs the same level on two consecutive visits, i.e. 65 to 128 strobes after the edge.
  - Pulses shorter than one scan period (64 strobes) are never committed.
- Commit:
  - The map entry KEYMAP[i] comes from the package ROM.
  - If KEYMAP[i] == 8'hFF (unmapped): stable[i] <= k and no event.
  - Otherwise, if the FIFO is not full: push {k, KEYMAP[i][6:0]} and stable[i] <= k. Press gives bit 7 = 0, release gives bit 7 = 1.
  - If the FIFO is full: no push, and stable[i] and sample[i] are left unchanged. The change is retried on the next visit, so no event is ever lost.
- FIFO:
  - Synchronous, first-word fall-through.
  - code and code_valid are registered from the head entry.
  - A pushed word appears on code one cycle after the push cycle if the FIFO was empty.
  - Pop occurs when code_valid & code_ready.
  - Full is evaluated at the start of the cycle. A pop in the same cycle does not allow a push into a full FIFO.
  - Simultaneous push and pop when not full leaves the level unchanged.
  - Order is strictly preserved.
- code holds its value when code_valid = 0 (last popped value, or 0 after reset).
- Reset mid-operation:
  - FIFO is flushed; code_valid = 0 on the cycle after reset is sampled.
  - Keys held across reset are reported as fresh presses after re-debounce.
  - No release events are synthesized for keys held at reset.
- ena_1mhz asserted on consecutive cycles is legal; each assertion advances one index.

Decomposition:
- Package c64_amiga_keymap_pkg:
  - KEYMAP 64x8 ROM constant with KEY_UNMAPPED = 8'hFF.
  - Required entries: index 0 = 8'h41 (INST/DEL -> Backspace), index 1 = 8'h44 (RETURN -> Return), index 60 = 8'h40 (SPACE -> Space), index 63 = KEY_UNMAPPED (reserved for menu key).
  - RELEASE_BIT = 7.
- One sub-module, key_event_fifo: parametrised synchronous FWFT FIFO with push, full, pop, valid, dout and level ports.

Test Plan:
- Reset, keys = all ones, 300 strobes -> code_valid stays 0, fifo_level = 0, code = 8'h00.
- keys[1] = 0 held -> code = 8'h44 with code_valid within 128 strobes, popped with code_ready = 1. keys[1] = 1 -> code = 8'hC4 within 128 strobes; exactly two events total.
- keys[0] = 0 for 40 strobes then 1 -> no event.
- keys[63] = 0 held for 3 scans -> no event.
- code_ready = 0, press 9 distinct mapped keys -> fifo_level saturates at 8, ninth not lost. Then code_ready = 1 -> 9 make codes emerge in scan-index order; the ninth arrives within one scan after space frees.
- 3 events queued, assert reset 1 cycle -> code_valid = 0 and fifo_level = 0 next cycle. The held key re-reports as a make code after debounce.
